// File: rtl/bin_search_ctrl.sv
// ---------------------------------------------------------------------------
// bin_search_ctrl
//
// Sequential initiator for a magnitude comparator. It drives a candidate onto
// the comparator B side, reads GT/LT/EQ back, and binary-searches the unknown
// value sitting on the A side. It is used to self-check comparator slices and
// to resolve thresholds without reading A directly.
//
// One probe is made every (SETTLE+1) cycles, with at most WIDTH+1 probes.
// Inconsistent flags, an exhausted range or a runaway probe count end the
// search with an error pulse.
//
// Ports
//   i_clk     rising-edge clock
//   i_rst     asynchronous, active-high reset
//   i_start   1-cycle pulse; starts a search when idle
//   i_GT      comparator: A >  o_guess
//   i_LT      comparator: A <  o_guess
//   i_EQ      comparator: A == o_guess
//   o_guess   registered candidate driven to comparator B (held when idle)
//   o_busy    search in progress
//   o_done    1-cycle pulse: search finished, o_result valid
//   o_err     1-cycle pulse, coincident with o_done: search failed
//   o_result  found value; held until the next accepted i_start
//   o_probes  probes used by the last search; held
// ---------------------------------------------------------------------------
module bin_search_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic                          i_GT,
    input  logic                          i_LT,
    input  logic                          i_EQ,
    output logic [WIDTH-1:0]              o_guess,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
    output logic [WIDTH-1:0]              o_result,
    output logic [$clog2(WIDTH+2)-1:0]    o_probes
);

    localparam int PW = $clog2(WIDTH + 2);

    // lo/hi carry one extra bit so lo can step past the top of the range
    // (lo = 2**WIDTH) without wrapping back to zero.
    localparam logic [WIDTH:0]   RANGE_MAX   = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   ONE_W1      = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] FIRST_GUESS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [PW-1:0]    PROBE_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    PROBE_LIMIT = PW'(WIDTH + 1);
    localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE > 0) ? (SETTLE - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_PROBE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // With no settle time the wait state is skipped entirely.
    localparam state_t ST_ISSUE = (SETTLE == 0) ? ST_PROBE : ST_WAIT;

    state_t            state_q,  state_d;
    logic [WIDTH:0]    lo_q,     lo_d;
    logic [WIDTH:0]    hi_q,     hi_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic [WIDTH-1:0]  guess_q,  guess_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [PW-1:0]     probes_q, probes_d;

    // Candidate bounds after a GT or LT answer, and the sums whose halves
    // give the next midpoint. All at WIDTH+1 bits; the sums cannot overflow
    // because lo <= 2**WIDTH and hi <= 2**WIDTH-1.
    logic [WIDTH:0] gt_lo, lt_hi, gt_sum, lt_sum;
    logic [PW-1:0]  probes_inc;

    assign gt_lo      = {1'b0, guess_q} + ONE_W1;
    assign lt_hi      = {1'b0, guess_q} - ONE_W1;
    assign gt_sum     = gt_lo + hi_q;
    assign lt_sum     = lo_q + lt_hi;
    assign probes_inc = probes_q + PROBE_ONE;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        guess_d  = guess_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = result_q;
        probes_d = probes_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    lo_d     = '0;
                    hi_d     = RANGE_MAX;
                    guess_d  = FIRST_GUESS;
                    probes_d = '0;
                    result_d = '0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_ISSUE;
                end
            end

            ST_WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_PROBE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_PROBE: begin
                probes_d = probes_inc;
                // Anything not explicitly resolved below is a failure:
                // no flag, several flags, exhausted range or probe limit.
                state_d  = ST_ERR;
                case ({i_GT, i_LT, i_EQ})
                    3'b001: begin
                        result_d = guess_q;
                        state_d  = ST_DONE;
                    end
                    3'b100: begin
                        if (gt_lo <= hi_q && probes_inc != PROBE_LIMIT) begin
                            lo_d    = gt_lo;
                            guess_d = WIDTH'(gt_sum >> 1);
                            state_d = ST_ISSUE;
                        end
                    end
                    3'b010: begin
                        if (guess_q != '0 && lo_q <= lt_hi &&
                            probes_inc != PROBE_LIMIT) begin
                            hi_d    = lt_hi;
                            guess_d = WIDTH'(lt_sum >> 1);
                            state_d = ST_ISSUE;
                        end
                    end
                    default: ;
                endcase

                if (state_d == ST_DONE) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if (state_d == ST_ERR) begin
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    busy_d   = 1'b0;
                    result_d = '0;
                end
            end

            // The pulse is already on the outputs; i_start is ignored here.
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            guess_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            probes_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            cnt_q    <= cnt_d;
            guess_q  <= guess_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            probes_q <= probes_d;
        end
    end

    assign o_guess  = guess_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_err    = err_q;
    assign o_result = result_q;
    assign o_probes = probes_q;

endmodule
